// File: rtl/calc_datapath.sv
// calc_datapath: calculator register/ALU datapath driven by synchronized control-unit level strobes
module calc_datapath #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         reset,
    input  logic [W-1:0] data_in,
    input  logic         LdA,
    input  logic         LdB,
    input  logic         LdR,
    input  logic         AddSub,
    input  logic         LdOU,
    input  logic         IUAU,
    output logic         out_sign,
    output logic [W-1:0] out_mag,
    output logic         ovf,
    output logic         r_valid,
    output logic         seq_err
);
    // Control bundle order: {IUAU, LdOU, AddSub, LdR, LdB, LdA, reset}; IUAU idles high.
    localparam logic [6:0] CTL_RST = 7'b100_0000;

    logic [6:0]   sync_q [SYNC_STAGES];
    logic [6:0]   s;
    logic [2:0]   edge_q, edge_d, pulse;
    logic [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d, out_q, out_d;
    logic         a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic         r_valid_q, r_valid_d, ovf_q, ovf_d, seq_err_q, seq_err_d;
    logic [W-1:0] b_op, sum;
    logic         sum_ovf;

    assign s     = sync_q[SYNC_STAGES-1];
    assign pulse = s[3:1] & ~edge_q;

    // Subtraction as A + ~B + 1 so one overflow rule covers both operations.
    assign b_op    = s[4] ? ~b_q : b_q;
    assign sum     = a_q + b_op + {{(W-1){1'b0}}, s[4]};
    assign sum_ovf = (a_q[W-1] == b_op[W-1]) && (sum[W-1] != a_q[W-1]);

    // Control inputs come from another timing domain: plain flop chain per bit.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= CTL_RST;
        end else begin
            sync_q[0] <= {IUAU, LdOU, AddSub, LdR, LdB, LdA, reset};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Next state: synced reset clears everything; otherwise apply one-shot loads and output tracking.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        out_d     = out_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        r_valid_d = r_valid_q;
        ovf_d     = ovf_q;
        seq_err_d = seq_err_q;
        edge_d    = s[3:1];
        if (s[0]) begin
            a_d       = '0;
            b_d       = '0;
            r_d       = '0;
            out_d     = '0;
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
            r_valid_d = 1'b0;
            ovf_d     = 1'b0;
            seq_err_d = 1'b0;
            edge_d    = '0;
        end else begin
            if (pulse[0]) begin
                a_d       = data_in;
                a_valid_d = 1'b1;
            end
            if (pulse[1]) begin
                b_d       = data_in;
                b_valid_d = 1'b1;
            end
            if (pulse[2] && a_valid_q && b_valid_q) begin
                r_d       = sum;
                ovf_d     = sum_ovf;
                r_valid_d = 1'b1;
                seq_err_d = 1'b0;
            end else if (pulse[2]) begin
                seq_err_d = 1'b1;
            end
            if (s[5]) out_d = s[6] ? data_in : r_q;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            out_q     <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            seq_err_q <= 1'b0;
            edge_q    <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            out_q     <= out_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            r_valid_q <= r_valid_d;
            ovf_q     <= ovf_d;
            seq_err_q <= seq_err_d;
            edge_q    <= edge_d;
        end
    end

    assign out_sign = out_q[W-1];
    assign out_mag  = out_q[W-1] ? -out_q : out_q;
    assign ovf      = ovf_q;
    assign r_valid  = r_valid_q;
    assign seq_err  = seq_err_q;
endmodule

// File: tb/tb_calc_datapath.sv
// tb_calc_datapath: scoreboard bench for the calculator datapath
`timescale 1ns/1ps
module tb_calc_datapath;
    localparam int W = 4;

    logic         clock = 1'b0, clear = 1'b0, reset = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         LdA = 1'b0, LdB = 1'b0, LdR = 1'b0, AddSub = 1'b0, LdOU = 1'b0, IUAU = 1'b1;
    logic         out_sign, ovf, r_valid, seq_err;
    logic [W-1:0] out_mag;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;

    calc_datapath #(.W(W), .SYNC_STAGES(2)) dut (
        .clock(clock), .clear(clear), .reset(reset), .data_in(data_in),
        .LdA(LdA), .LdB(LdB), .LdR(LdR), .AddSub(AddSub), .LdOU(LdOU), .IUAU(IUAU),
        .out_sign(out_sign), .out_mag(out_mag), .ovf(ovf), .r_valid(r_valid), .seq_err(seq_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] mk(input logic o, input logic rv, input logic se, input logic sg, input logic [3:0] m);
        return {o, rv, se, sg, m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [7:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop_check();
        exp_t e;
        e = (sb.size() != 0) ? sb.pop_front() : '{"sb_empty", 8'hxx};
        check(e.tag, {24'd0, ovf, r_valid, seq_err, out_sign, out_mag}, {24'd0, e.val});
    endtask

    task automatic lda(input logic [W-1:0] v);
        @(negedge clock); data_in = v; LdA = 1'b1;
        repeat (2) @(negedge clock);
        LdA = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic ldb(input logic [W-1:0] v);
        @(negedge clock); data_in = v; LdB = 1'b1;
        repeat (2) @(negedge clock);
        LdB = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic ldr(input logic sub);
        @(negedge clock); AddSub = sub; LdR = 1'b1;
        repeat (2) @(negedge clock);
        LdR = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        push("reset", 8'h00); pop_check();
        check("reset_A", 32'(dut.a_q), 0);
        clear = 1'b1; LdOU = 1'b1; IUAU = 1'b0;

        lda(4'd3); ldb(4'd5);
        push("add_ovf", mk(1, 1, 0, 1, 4'd8)); ldr(1'b0); pop_check();
        check("add_R", 32'(dut.r_q), 32'h8);
        push("sub", mk(0, 1, 0, 1, 4'd2)); ldr(1'b1); pop_check();
        check("sub_R", 32'(dut.r_q), 32'he);

        @(negedge clock); data_in = 4'd3; LdA = 1'b1;
        repeat (5) @(negedge clock);
        data_in = 4'd7;
        repeat (5) @(negedge clock);
        LdA = 1'b0;
        repeat (4) @(negedge clock);
        check("held_lda_A", 32'(dut.a_q), 3);

        lda(4'h8); ldb(4'd1);
        push("sub_ovf", mk(1, 1, 0, 0, 4'd7)); ldr(1'b1); pop_check();
        push("add_neg", mk(0, 1, 0, 1, 4'd7)); ldr(1'b0); pop_check();

        @(negedge clock); clear = 1'b0;
        #1 push("clear", 8'h00); pop_check();
        @(negedge clock); clear = 1'b1;
        lda(4'd2);
        push("seq_err", mk(0, 0, 1, 0, 4'd0)); ldr(1'b0); pop_check();
        check("seq_R", 32'(dut.r_q), 0);
        ldb(4'd1);
        push("seq_ok", mk(0, 1, 0, 0, 4'd3)); ldr(1'b0); pop_check();

        @(negedge clock); IUAU = 1'b1; data_in = 4'ha;
        push("iu_pass", mk(0, 1, 0, 1, 4'd6));
        repeat (3) @(negedge clock);
        pop_check();
        LdOU = 1'b0;
        repeat (3) @(negedge clock);
        data_in = 4'd1;
        push("ou_hold", mk(0, 1, 0, 1, 4'd6));
        repeat (4) @(negedge clock);
        pop_check();

        LdOU = 1'b1; IUAU = 1'b0; AddSub = 1'b0;
        repeat (4) @(negedge clock);
        LdR = 1'b1;
        @(negedge clock); clear = 1'b0;
        #1 push("clear_mid", 8'h00); pop_check();
        @(negedge clock); LdR = 1'b0; clear = 1'b1;
        repeat (4) @(negedge clock);

        @(negedge clock); reset = 1'b1; data_in = 4'd5; LdA = 1'b1;
        repeat (3) @(negedge clock);
        LdA = 1'b0;
        @(negedge clock); reset = 1'b0;
        push("rst_out", 8'h00);
        repeat (5) @(negedge clock);
        pop_check();
        check("rst_A", 32'(dut.a_q), 0);

        lda(4'd5);
        check("post_rst_A", 32'(dut.a_q), 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
